// File: rtl/weight_writer_pkg.sv
// Shared definitions for the weight writer: FSM state encoding and the
// default word and address widths used by the top and its address generator.
package weight_writer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : weight_writer_pkg

// File: rtl/wr_addr_gen.sv
// Address/count generator for a write burst: loads the base address and
// word count, then advances the address (wrapping at the top of memory)
// and decrements the remaining count once per accepted beat.
module wr_addr_gen
    import weight_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH:0]   i_length,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;

    // Load on burst start, otherwise advance address and count per accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_length;
        end else if (i_step) begin
            // Natural overflow of the ADDR_WIDTH-bit register gives the wrap to 0.
            r_addr <= r_addr + 1'b1;
            if (r_remaining != '0) begin
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});

endmodule : wr_addr_gen

// File: rtl/weight_writer.sv
// Weight writer: accepts a burst of words on a valid/ready stream and writes
// them to consecutive memory addresses with one cycle of registered latency,
// accumulating a running checksum of the accepted words.
module weight_writer
    import weight_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    state_t r_state;
    state_t w_next_state;

    logic                  w_start_acc;
    logic                  w_len_nz;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_cur_addr;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_checksum;

    // Ready depends only on state so the upstream never sees a valid->ready loop.
    assign s_ready     = (r_state == LOAD);
    assign busy        = (r_state == LOAD) || (r_state == DONE);
    assign done        = (r_state == DONE);
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_len_nz    = (length != '0);
    assign w_accept    = s_valid && s_ready;
    assign w_load      = w_start_acc && w_len_nz;

    wr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_base   (base_addr),
        .i_length (length),
        .i_step   (w_accept),
        .o_addr   (w_cur_addr),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort takes priority over completing on the last beat.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = w_len_nz ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (w_accept && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Register each accepted beat into a memory write one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_cur_addr;
                r_wr_data <= s_data;
            end
        end
    end

    // Checksum clears on any accepted start and accumulates every accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + s_data;
        end
    end

    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;
    assign checksum    = r_checksum;

endmodule : weight_writer
